// File: rtl/store_w_commit_pkg.sv
// Shared types and defaults for the vector store W-commit path.
package vlsu_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_e;

    localparam int unsigned StoreCommitDepth    = 4;
    localparam int unsigned StoreMaxOutstanding = 8;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
        logic [1:0]  user;
    } axi_w_default_t;

    // Only a literal OKAY counts as success; EXOKAY is treated as an error here.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != OKAY;
    endfunction

endpackage

// File: rtl/store_w_commit_if.sv
// Bundles the store-unit W input, AXI W/B channels, AW observation and completion outputs.
interface store_w_commit_if
    import vlsu_pkg::*;
#(
    parameter type axi_w_t = axi_w_default_t
);
    // valid/ready: a transfer happens on a clock edge where both are high; the
    // sender keeps valid and payload stable until that edge.
    logic       w_valid_i;
    logic       w_ready_o;
    axi_w_t     w_i;
    logic       axi_w_valid_o;
    logic       axi_w_ready_i;
    axi_w_t     axi_w_o;
    logic       aw_fire_i;
    logic       aw_last_i;
    logic       aw_stall_o;
    logic       axi_b_valid_i;
    logic       axi_b_ready_o;
    logic [1:0] axi_b_resp_i;
    logic       store_done_o;
    logic       store_err_o;

    modport slave (
        input  w_valid_i, w_i, axi_w_ready_i, aw_fire_i, aw_last_i,
               axi_b_valid_i, axi_b_resp_i,
        output w_ready_o, axi_w_valid_o, axi_w_o, aw_stall_o, axi_b_ready_o,
               store_done_o, store_err_o
    );

    modport master (
        output w_valid_i, w_i, axi_w_ready_i, aw_fire_i, aw_last_i,
               axi_b_valid_i, axi_b_resp_i,
        input  w_ready_o, axi_w_valid_o, axi_w_o, aw_stall_o, axi_b_ready_o,
               store_done_o, store_err_o
    );

endinterface

// File: rtl/store_w_commit_fifo.sv
// Generic registered FIFO (no fall-through); storage is cleared on reset so the head reads zero.
module store_w_fifo #(
    parameter type         T     = logic,
    parameter int unsigned Depth = 4,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  T                push_data,
    input  logic            pop,
    output T                head,
    output logic            empty,
    output logic [CntW-1:0] count
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    T                mem [Depth];
    logic [PtrW-1:0] rd_ptr, wr_ptr;
    logic [CntW-1:0] cnt;
    logic            do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign do_push = push && (cnt < CntW'(Depth));
    assign do_pop  = pop && (cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < Depth; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)      cnt <= cnt + CntW'(1);
            else if (do_pop && !do_push) cnt <= cnt - CntW'(1);
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/store_w_commit.sv
// Holds W beats until their AW burst is on the bus, tracks bursts awaiting B,
// and pulses per-instruction completion with an aggregated error.
module store_w_commit
    import vlsu_pkg::*;
#(
    parameter int unsigned Depth          = StoreCommitDepth,
    parameter int unsigned MaxOutstanding = StoreMaxOutstanding,
    parameter type         axi_w_t        = axi_w_default_t
) (
    input logic              clk_i,
    input logic              rst_i,
    store_w_commit_if.slave  bus
);
    localparam int unsigned FifoCntW = $clog2(Depth + 1);
    localparam int unsigned CntW     = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW     = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    logic [FifoCntW-1:0]     fifo_count;
    logic                    fifo_empty, w_ready, w_push, w_valid_out, w_pop, last_pop;
    axi_w_t                  fifo_head;
    logic [CntW-1:0]         pend_aw, occ;
    logic [PtrW-1:0]         head, tail;
    logic [MaxOutstanding-1:0] flags;
    logic                    aw_stall, aw_push, b_pop, resp_err, done_set;
    logic                    err_acc, store_done, store_err;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
    endfunction

    store_w_fifo #(.T(axi_w_t), .Depth(Depth)) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (w_push),
        .push_data (bus.w_i),
        .pop       (w_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign w_ready     = fifo_count < FifoCntW'(Depth);
    assign w_push      = bus.w_valid_i && w_ready;
    assign w_valid_out = !fifo_empty && (pend_aw != '0);
    assign w_pop       = w_valid_out && bus.axi_w_ready_i;
    assign last_pop    = w_pop && fifo_head.last;

    // A burst's beats may only leave once its AW has been accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_aw <= '0;
        end else if (aw_push && !last_pop) begin
            pend_aw <= pend_aw + CntW'(1);
        end else if (last_pop && !aw_push) begin
            pend_aw <= pend_aw - CntW'(1);
        end
    end

    // A B in the same cycle frees a slot, so a full queue may still accept an AW.
    assign aw_stall = (occ == CntW'(MaxOutstanding));
    assign b_pop    = bus.axi_b_valid_i && (occ != '0);
    assign aw_push  = bus.aw_fire_i && (!aw_stall || b_pop);
    assign resp_err = resp_is_err(bus.axi_b_resp_i);
    assign done_set = b_pop && flags[head];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head  <= '0;
            tail  <= '0;
            occ   <= '0;
            flags <= '0;
        end else begin
            if (aw_push) begin
                flags[tail] <= bus.aw_last_i;
                tail        <= ptr_inc(tail);
            end
            if (b_pop) head <= ptr_inc(head);
            if (aw_push && !b_pop)      occ <= occ + CntW'(1);
            else if (b_pop && !aw_push) occ <= occ - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_acc    <= 1'b0;
            store_done <= 1'b0;
            store_err  <= 1'b0;
        end else begin
            store_done <= done_set;
            store_err  <= done_set && (err_acc || resp_err);
            if (b_pop) err_acc <= done_set ? 1'b0 : (err_acc || resp_err);
        end
    end

    assign bus.w_ready_o     = w_ready;
    assign bus.axi_w_valid_o = w_valid_out;
    assign bus.axi_w_o       = fifo_head;
    assign bus.aw_stall_o    = aw_stall;
    assign bus.axi_b_ready_o = 1'b1;
    assign bus.store_done_o  = store_done;
    assign bus.store_err_o   = store_err;

    a_aw_while_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(bus.aw_fire_i && !aw_push));
    a_b_while_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        !(bus.axi_b_valid_i && occ == '0));
    a_w_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (w_valid_out && !bus.axi_w_ready_i) |=> (w_valid_out && $stable(fifo_head)));

endmodule

// File: tb/tb_store_w_commit.sv
// Randomized bench for store_w_commit: instruction-level reference model, expected queues, per-cycle monitor.
module tb_store_w_commit;
    import vlsu_pkg::*;

    localparam int DEPTH = 4;
    localparam int MAX   = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    store_w_commit_if bus ();

    store_w_commit #(
        .Depth          (DEPTH),
        .MaxOutstanding (MAX),
        .axi_w_t        (axi_w_default_t)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic err;
        int   due;
    } done_t;

    axi_w_default_t exp_w_q[$];
    done_t          exp_done_q[$];

    // Stimulus plan: beats in order, plus the "last burst of instruction" flag per burst.
    axi_w_default_t beats[$];
    bit             burst_last[$];
    int             w_idx, aw_next, b_next;
    bit             inst_err;

    // Model of the state the DUT holds after each clock edge.
    int fifo_cnt, aw_cnt, b_cnt, wdone, cyc;
    bit after_reset;
    bit exp_valid, exp_done, mon_pop, mon_push;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic drive_idle();
        bus.w_valid_i     = 1'b0;
        bus.w_i           = '0;
        bus.axi_w_ready_i = 1'b0;
        bus.aw_fire_i     = 1'b0;
        bus.aw_last_i     = 1'b0;
        bus.axi_b_valid_i = 1'b0;
        bus.axi_b_resp_i  = 2'b00;
    endtask

    task automatic gen_traffic(input int n_inst);
        for (int i = 0; i < n_inst; i++) begin
            int nb;
            nb = int'($urandom_range(1, 3));
            for (int b = 0; b < nb; b++) begin
                int len;
                len = int'($urandom_range(1, 4));
                burst_last.push_back(b == nb - 1);
                for (int k = 0; k < len; k++) begin
                    axi_w_default_t w;
                    w.data = $urandom;
                    w.strb = 4'($urandom);
                    w.last = (k == len - 1);
                    w.user = 2'($urandom);
                    beats.push_back(w);
                end
            end
        end
    endtask

    task automatic drive_cycle(input int unsigned pw, input int unsigned paw,
                               input int unsigned pb, input int unsigned pwr);
        int occ;
        logic [1:0] resp;
        @(posedge clk);
        #1;
        occ = aw_next - b_next;
        if (w_idx < beats.size() && $urandom_range(0, 99) < pw) begin
            bus.w_valid_i = 1'b1;
            bus.w_i       = beats[w_idx];
            if (fifo_cnt < DEPTH) begin
                exp_w_q.push_back(beats[w_idx]);
                w_idx++;
            end
        end else begin
            bus.w_valid_i = 1'b0;
            bus.w_i       = '0;
        end
        if (b_next < wdone && $urandom_range(0, 99) < pb) begin
            resp = ($urandom_range(0, 9) < 7) ? 2'b00 : 2'($urandom_range(1, 3));
            bus.axi_b_valid_i = 1'b1;
            bus.axi_b_resp_i  = resp;
            inst_err = inst_err | (resp != 2'b00);
            if (burst_last[b_next]) begin
                exp_done_q.push_back('{err: inst_err, due: cyc + 1});
                inst_err = 1'b0;
            end
            b_next++;
        end else begin
            bus.axi_b_valid_i = 1'b0;
            bus.axi_b_resp_i  = 2'($urandom);
        end
        if (aw_next < burst_last.size() && $urandom_range(0, 99) < paw &&
            (occ < MAX || bus.axi_b_valid_i)) begin
            bus.aw_fire_i = 1'b1;
            bus.aw_last_i = burst_last[aw_next];
            aw_next++;
        end else begin
            bus.aw_fire_i = 1'b0;
            bus.aw_last_i = 1'($urandom);
        end
        bus.axi_w_ready_i = ($urandom_range(0, 99) < pwr);
    endtask

    function automatic bit drained();
        return w_idx == beats.size() && b_next == burst_last.size() &&
               exp_done_q.size() == 0 && fifo_cnt == 0;
    endfunction

    task automatic run_phase(input int n_inst, input int unsigned pw, input int unsigned paw,
                             input int unsigned pb, input int unsigned pwr,
                             input int max_cycles, input bit must_drain);
        int cycles;
        cycles = 0;
        gen_traffic(n_inst);
        while (!drained() && cycles < max_cycles) begin
            drive_cycle(pw, paw, pb, pwr);
            cycles++;
        end
        if (must_drain) check("drain", 64'(drained()), 64'(1));
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        drive_idle();
        rst = 1'b1;
        beats.delete();
        burst_last.delete();
        w_idx    = 0;
        aw_next  = 0;
        b_next   = 0;
        inst_err = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compares DUT outputs to the model, then advances the model by this cycle's inputs.
    always @(negedge clk) begin
        if (rst) begin
            exp_w_q.delete();
            exp_done_q.delete();
            fifo_cnt    = 0;
            aw_cnt      = 0;
            b_cnt       = 0;
            wdone       = 0;
            after_reset = 1'b1;
        end else begin
            exp_valid = (fifo_cnt > 0) && (aw_cnt > wdone);
            check("w_ready", 64'(bus.w_ready_o), 64'(fifo_cnt < DEPTH));
            check("aw_stall", 64'(bus.aw_stall_o), 64'((aw_cnt - b_cnt) == MAX));
            check("axi_w_valid", 64'(bus.axi_w_valid_o), 64'(exp_valid));
            check("b_ready", 64'(bus.axi_b_ready_o), 64'(1));
            if (exp_valid && exp_w_q.size() > 0)
                check("axi_w_beat", 64'(bus.axi_w_o), 64'(exp_w_q[0]));
            if (after_reset) begin
                check("reset_w_beat", 64'(bus.axi_w_o), 64'(0));
                check("reset_err", 64'(bus.store_err_o), 64'(0));
                after_reset = 1'b0;
            end
            exp_done = (exp_done_q.size() > 0) && (exp_done_q[0].due == cyc);
            check("store_done", 64'(bus.store_done_o), 64'(exp_done));
            if (exp_done) begin
                check("store_err", 64'(bus.store_err_o), 64'(exp_done_q[0].err));
                void'(exp_done_q.pop_front());
            end
            mon_pop  = exp_valid && bus.axi_w_ready_i;
            mon_push = bus.w_valid_i && (fifo_cnt < DEPTH);
            if (mon_pop && exp_w_q.size() > 0) begin
                if (exp_w_q[0].last) wdone++;
                void'(exp_w_q.pop_front());
            end
            if (mon_push) fifo_cnt++;
            if (mon_pop)  fifo_cnt--;
            if (bus.aw_fire_i)     aw_cnt++;
            if (bus.axi_b_valid_i) b_cnt++;
        end
        cyc++;
    end

    initial begin
        cyc = 0;
        drive_idle();
        rst = 1'b1;
        do_reset();
        run_phase(10, 70, 50, 50, 70, 3000, 1'b1);
        run_phase(8, 90, 90, 8, 90, 3000, 1'b1);
        run_phase(8, 90, 5, 60, 30, 3000, 1'b1);
        run_phase(4, 100, 100, 0, 0, 3, 1'b0);
        do_reset();
        run_phase(10, 70, 50, 50, 70, 3000, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
